// File: rtl/fpu_sub_sched.sv
// Two-port round-robin scheduler that shares one single-precision subtractor.
// Also holds the combinational IEEE-754 binary32 subtractor fsub (round to nearest even).

module fsub (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y,
    output logic        ovf
);
    logic        sa, sb, swap, xs, ys, eff_sub, rs, rnd;
    logic        a_nan, b_nan, a_inf, b_inf;
    logic [7:0]  xe, ye;
    logic [22:0] xf, yf;
    logic [9:0]  xexp, yexp, d, ex, exn, lz, sh;
    logic [26:0] mx, my, mys, m, mn;
    logic [27:0] sum;
    logic [30:0] pk, pkr;

    always_comb begin
        y       = '0;
        ovf     = 1'b0;
        lz      = 10'd27;
        sa      = a[31];
        sb      = ~b[31];
        a_nan   = (a[30:23] == 8'hFF) && (a[22:0] != '0);
        b_nan   = (b[30:23] == 8'hFF) && (b[22:0] != '0);
        a_inf   = (a[30:23] == 8'hFF) && (a[22:0] == '0);
        b_inf   = (b[30:23] == 8'hFF) && (b[22:0] == '0);
        swap    = b[30:0] > a[30:0];
        xs      = swap ? sb : sa;
        ys      = swap ? sa : sb;
        xe      = swap ? b[30:23] : a[30:23];
        xf      = swap ? b[22:0]  : a[22:0];
        ye      = swap ? a[30:23] : b[30:23];
        yf      = swap ? a[22:0]  : b[22:0];
        xexp    = (xe == 8'd0) ? 10'd1 : {2'b00, xe};
        yexp    = (ye == 8'd0) ? 10'd1 : {2'b00, ye};
        mx      = {xe != 8'd0, xf, 3'b000};
        my      = {ye != 8'd0, yf, 3'b000};
        d       = xexp - yexp;
        // Smaller operand is aligned with guard/round bits and a sticky LSB
        if (d >= 10'd27)
            mys = {26'b0, |my};
        else
            mys = (my >> d) | {26'b0, |(my & ~(27'h7FFFFFF << d))};
        eff_sub = xs ^ ys;
        sum     = eff_sub ? ({1'b0, mx} - {1'b0, mys}) : ({1'b0, mx} + {1'b0, mys});
        if (sum[27]) begin
            m  = {sum[27:2], sum[1] | sum[0]};
            ex = xexp + 10'd1;
        end else begin
            m  = sum[26:0];
            ex = xexp;
        end
        for (int unsigned i = 0; i < 27; i++)
            if (m[i]) lz = 10'(26 - i);
        // Left shift stops at the minimum exponent, leaving a subnormal
        sh      = (lz < ex - 10'd1) ? lz : ex - 10'd1;
        mn      = m << sh;
        exn     = ex - sh;
        rs      = (sum == '0) ? (xs & ~eff_sub) : xs;
        pk      = {(mn[26] ? exn[7:0] : 8'd0), mn[25:3]};
        rnd     = mn[2] & (mn[1] | mn[0] | mn[3]);
        pkr     = pk + {30'b0, rnd};

        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
            y = 32'h7FC00000;
        end else if (a_inf) begin
            y = {sa, 8'hFF, 23'b0};
        end else if (b_inf) begin
            y = {sb, 8'hFF, 23'b0};
        end else if ((exn >= 10'd255) || (pkr[30:23] == 8'hFF)) begin
            y   = {rs, 8'hFF, 23'b0};
            ovf = 1'b1;
        end else begin
            y = {rs, pkr};
        end
    end
endmodule

module fpu_sub_sched (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_x1,
    input  logic [31:0] req0_x2,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_x1,
    input  logic [31:0] req1_x2,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_y,
    output logic        rsp0_ovf,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_y,
    output logic        rsp1_ovf,
    output logic        busy,
    output logic [15:0] ops_done,
    output logic        ovf_sticky,
    input  logic        ovf_clr
);
    typedef enum logic {IDLE, EXEC} state_t;

    state_t      state, state_nx;
    logic        rr, owner, elig0, elig1, win, accept, done;
    logic [31:0] opa, opb, fy;
    logic        fovf;

    fsub u_fsub (
        .a   (opa),
        .b   (opb),
        .y   (fy),
        .ovf (fovf)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        done       = 1'b0;
        busy       = 1'b0;
        elig0      = req0_valid & ~rsp0_valid;
        elig1      = req1_valid & ~rsp1_valid;
        win        = (elig0 & elig1) ? rr : elig1;
        case (state)
            IDLE: begin
                // Ready is masked while reset is held so nothing is granted before the first live edge
                if (rstn && (elig0 || elig1)) begin
                    accept     = 1'b1;
                    req0_ready = ~win;
                    req1_ready = win;
                    state_nx   = EXEC;
                end
            end
            EXEC: begin
                done     = 1'b1;
                busy     = 1'b1;
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr         <= 1'b0;
            owner      <= 1'b0;
            opa        <= '0;
            opb        <= '0;
            rsp0_valid <= 1'b0;
            rsp0_y     <= '0;
            rsp0_ovf   <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp1_y     <= '0;
            rsp1_ovf   <= 1'b0;
            ops_done   <= '0;
            ovf_sticky <= 1'b0;
        end else begin
            if (accept) begin
                opa   <= win ? req1_x1 : req0_x1;
                opb   <= win ? req1_x2 : req0_x2;
                owner <= win;
                rr    <= ~win;
            end
            if (done)
                ops_done <= ops_done + 16'd1;
            rsp0_valid <= (done & ~owner) | (rsp0_valid & ~rsp0_ready);
            rsp1_valid <= (done & owner) | (rsp1_valid & ~rsp1_ready);
            if (done && !owner) begin
                rsp0_y   <= fy;
                rsp0_ovf <= fovf;
            end
            if (done && owner) begin
                rsp1_y   <= fy;
                rsp1_ovf <= fovf;
            end
            ovf_sticky <= (done & fovf) | (ovf_sticky & ~ovf_clr);
        end
    end
endmodule

// File: doc/fpu_sub_sched.md
FPU_SUB_SCHED -- requirements
Module: fpu_sub_sched

Interface
REQ-001 The block SHALL have no parameters; all widths and timing are fixed by this document.
REQ-002 clk  input  1  the single clock; all state updates on rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle when high with req0_valid.
REQ-006 req0_x1, req0_x2  input  32 each  requester 0 IEEE-754 single operands; result = x1 - x2.
REQ-007 req1_valid, req1_ready, req1_x1, req1_x2  same widths and meanings as REQ-004..006, for requester 1.
REQ-008 rsp0_valid  output  1  result for requester 0 is held.
REQ-009 rsp0_ready  input  1  requester 0 consumes its result.
REQ-010 rsp0_y  output  32  result word; rsp0_ovf  output  1  overflow flag of that result.
REQ-011 rsp1_valid, rsp1_ready, rsp1_y, rsp1_ovf  same as REQ-008..010, for requester 1.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 ops_done  output  16  count of completed subtractions, wraps 0xFFFF -> 0x0000.
REQ-014 ovf_sticky  output  1  set by any completed result with ovf=1; ovf_clr  input  1  clears it.

Function
REQ-015 The block SHALL instantiate exactly one fsub and share it between both requesters.
REQ-016 FSM states: IDLE, EXEC; IDLE -> EXEC on an accepted request; EXEC -> IDLE unconditionally after one cycle.
REQ-017 Eligibility: requester i is eligible in IDLE iff reqi_valid=1 and rspi_valid=0 (one outstanding result per port).
REQ-018 Arbitration: round-robin via 1-bit pointer rr; when both are eligible, requester rr wins; when one is eligible, it wins regardless of rr.
REQ-019 reqi_ready SHALL be high only in IDLE, only for the winner, and combinationally derived from that cycle's valids; at most one ready per cycle.
REQ-020 On an accept edge: operands latched into opA/opB registers, owner id latched, rr set to the non-winner.
REQ-021 In EXEC the fsub inputs SHALL come only from opA/opB registers; at the EXEC->IDLE edge {y, ovf} are written into the owner's response register and rspi_valid is set.
REQ-022 Latency: accept at edge N -> rspi_valid=1 after edge N+1; next accept earliest at edge N+2 (one op per 2 cycles).
REQ-023 rspi_valid, rspi_y, rspi_ovf SHALL stay stable until the edge where rspi_ready=1; that edge clears rspi_valid.
REQ-024 If rspi_ready=1 in the same cycle as eligibility is evaluated, the port is still ineligible that cycle (no bypass).
REQ-025 ops_done increments by 1 at every EXEC->IDLE edge; wraps modulo 2^16.
REQ-026 ovf_sticky: set at EXEC->IDLE edge if the fsub ovf=1; ovf_clr=1 clears it; simultaneous set and clear -> set wins.
REQ-027 req inputs while not ready SHALL be ignored; operands need only be valid on the accept cycle.

Reset
REQ-028 rstn=0 SHALL immediately force: state=IDLE, rr=0, req0_ready=req1_ready=0, rsp0_valid=rsp1_valid=0, rsp0_y=rsp1_y=0, rsp0_ovf=rsp1_ovf=0, ops_done=0, ovf_sticky=0, busy=0, opA=opB=0.
REQ-029 Reset asserted during EXEC SHALL discard the operation: no response, no count, no sticky update.
REQ-030 After rstn deasserts, the first accept SHALL occur no earlier than the first rising edge with rstn=1.

Verification
REQ-031 req0 x1=0x40400000, x2=0x3F800000 -> req0_ready=1 cycle 0, rsp0_valid after edge 1 with rsp0_y=0x40000000, rsp0_ovf=0, ops_done=1.
REQ-032 Both valid every cycle after reset, rsp_ready=1 -> grants alternate 0,1,0,1; every 2 cycles one response; rr toggles.
REQ-033 req1 x1=0x7F7FFFFF, x2=0xFF7FFFFF -> rsp1_y=0x7F800000, rsp1_ovf=1, ovf_sticky=1; ovf_clr pulsed same edge as a second overflow -> ovf_sticky stays 1.
REQ-034 rsp0_ready=0 held, req0 valid continuously with req1 idle -> exactly one req0 accept, rsp0 held stable; x1=0x7FC00000, x2=0x3F800000 -> rsp0_y=0x7FC00000; req1 still served meanwhile.
REQ-035 rstn pulsed low during EXEC -> no rsp_valid, ops_done=0; preload ops_done=0xFFFF via 65535 ops then one more -> ops_done=0x0000.
